// File: rtl/pc_ctrl.sv
// Program-counter controller: IDLE/RUN/HALT sequencer with relative/absolute
// branching through an external target table and a small return stack.
module pc_ctrl #(
    parameter int D  = 12,
    parameter int SD = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         stall_i,
    input  logic         halt_i,
    input  logic         branch_en_i,
    input  logic [2:0]   branch_sel_i,
    input  logic         call_i,
    input  logic         ret_i,
    output logic [2:0]   lut_addr_o,
    input  logic [D-1:0] lut_target_i,
    output logic [D-1:0] pc_o,
    output logic         done_o,
    output logic         stack_ovf_o,
    output logic         stack_unf_o
);

    localparam int SPW = $clog2(SD + 1);
    localparam int IW  = (SD > 1) ? $clog2(SD) : 1;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t         state_q;
    logic [D-1:0]   pc_q;
    logic [D-1:0]   stack_q [SD];
    logic [SPW-1:0] sp_q;
    logic           done_q;
    logic           ovf_q;
    logic           unf_q;

    logic [D-1:0]   pc_inc_d;
    logic [D-1:0]   pc_rel_d;
    logic [IW-1:0]  push_idx_d;
    logic [IW-1:0]  top_idx_d;
    logic           stack_full_d;
    logic           stack_empty_d;

    assign lut_addr_o = branch_sel_i;

    // Relative targets wrap modulo 2^D, so two's-complement add needs no sign handling.
    assign pc_inc_d      = pc_q + D'(1);
    assign pc_rel_d      = pc_q + lut_target_i;
    assign push_idx_d    = IW'(sp_q);
    assign top_idx_d     = IW'(sp_q - SPW'(1));
    assign stack_full_d  = (sp_q == SPW'(SD));
    assign stack_empty_d = (sp_q == '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < SD; i++) stack_q[i] <= '0;
        end else begin
            case (state_q)
                IDLE, HALT: begin
                    if (start_i) begin
                        state_q <= RUN;
                        pc_q    <= '0;
                        sp_q    <= '0;
                        done_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        unf_q   <= 1'b0;
                    end
                end
                RUN: begin
                    if (stall_i) begin
                        state_q <= RUN;
                    end else if (halt_i) begin
                        state_q <= HALT;
                        done_q  <= 1'b1;
                    end else if (ret_i) begin
                        if (!stack_empty_d) begin
                            pc_q <= stack_q[top_idx_d];
                            sp_q <= sp_q - SPW'(1);
                        end else begin
                            pc_q  <= pc_inc_d;
                            unf_q <= 1'b1;
                        end
                    end else if (branch_en_i) begin
                        pc_q <= branch_sel_i[2] ? lut_target_i : pc_rel_d;
                        // A call on a full stack still branches; only the link is lost.
                        if (call_i) begin
                            if (!stack_full_d) begin
                                stack_q[push_idx_d] <= pc_inc_d;
                                sp_q                <= sp_q + SPW'(1);
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end
                    end else begin
                        pc_q <= pc_inc_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pc_o        = pc_q;
    assign done_o      = done_q;
    assign stack_ovf_o = ovf_q;
    assign stack_unf_o = unf_q;

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameter D, default 12, PC and branch-target width in bits.
REQ-002 Parameter SD, default 4, return-stack depth in entries.
REQ-003 Clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Reset  input  1  synchronous, active-low; when low at a rising edge, all state is reset.
REQ-005 Start  input  1  begins execution at PC 0 from IDLE or HALT.
REQ-006 Stall  input  1  holds PC and stack for one cycle while in RUN.
REQ-007 Halt  input  1  ends the program; enters HALT.
REQ-008 BranchEn  input  1  takes a branch via the target table this cycle.
REQ-009 BranchSel  input  3  target-table index for the branch.
REQ-010 Call  input  1  qualifies BranchEn as jump-and-link.
REQ-011 Ret  input  1  pops the return stack into PC.
REQ-012 LutAddr  output  3  index driven to the target table.
REQ-013 LutTarget  input  D  target returned by the table, combinational from LutAddr.
REQ-014 PC  output  D  current program counter.
REQ-015 Done  output  1  high while in HALT.
REQ-016 StackOvf  output  1  sticky push-on-full error.
REQ-017 StackUnf  output  1  sticky pop-on-empty error.

Function
REQ-018 LutAddr shall equal BranchSel combinationally in every state.
REQ-019 The FSM shall have three states: IDLE, RUN and HALT.
REQ-020 IDLE: Start=1 -> RUN, PC=0, stack emptied, StackOvf=0 and StackUnf=0; otherwise IDLE with PC held.
REQ-021 RUN evaluates its inputs with fixed priority: Stall > Halt > Ret > BranchEn > increment.
REQ-022 RUN, Stall=1: PC, stack and state shall hold, and all other inputs are ignored.
REQ-023 RUN, Halt=1: next state HALT, PC held, Done=1 from the following cycle.
REQ-024 RUN, Ret=1 with stack non-empty: PC = top entry, pop one.
REQ-025 RUN, Ret=1 with stack empty: PC = PC+1, StackUnf set.
REQ-026 RUN, BranchEn=1 with BranchSel[2]=0 (relative): PC = (PC + LutTarget) mod 2^D, with LutTarget treated as two's complement.
REQ-027 RUN, BranchEn=1 with BranchSel[2]=1 (absolute): PC = LutTarget.
REQ-028 RUN, BranchEn=1 and Call=1: additionally push (PC+1) mod 2^D.
REQ-029 Push with stack full (SD entries): the push is discarded, StackOvf is set, and the branch is still taken.
REQ-030 Call=1 without BranchEn shall be ignored.
REQ-031 Call=1 with Ret=1: Ret wins and no push occurs.
REQ-032 RUN, no control input active: PC = (PC+1) mod 2^D, so 2^D-1 wraps to 0.
REQ-033 HALT: PC held, Done=1; Start=1 -> RUN with the same clearing actions as REQ-020.
REQ-034 Stall, Halt, BranchEn, Call and Ret shall be ignored in IDLE and HALT.
REQ-035 StackOvf and StackUnf stay set until Reset or Start.
REQ-036 Branch latency: the new PC is visible on the first rising edge after BranchEn is sampled, with no bubble.
REQ-037 Start asserted in RUN shall be ignored.

Reset
REQ-038 While Reset=0 at a rising edge: state = IDLE, PC=0, Done=0, stack empty, StackOvf=0, StackUnf=0.
REQ-039 Reset shall override every other input in every state, including mid-branch and mid-stall.
REQ-040 Operation resumes only once Reset=1 and Start=1.

Verification
REQ-041 Bench: Reset low 2 cycles, then Start -> PC=0, RUN; 4 idle cycles -> PC=4; BranchEn, BranchSel=011, LutTarget=0xFFF -> PC=3.
REQ-042 Bench: PC=4090, BranchEn, BranchSel=010, LutTarget=20 -> PC=14 (wrap); PC=4095 with no input -> PC=0.
REQ-043 Bench: PC=7, BranchEn+Call, BranchSel=100, LutTarget=100 -> PC=100, stack top=8; then Ret -> PC=8, stack empty.
REQ-044 Bench: 5 nested calls with SD=4 -> 5th branch taken, StackOvf=1, 4 Rets return in LIFO order; 5th Ret -> PC+1, StackUnf=1.
REQ-045 Bench: Stall+BranchEn at PC=10 -> PC=10; Halt+Ret at PC=10 -> HALT, Done=1, PC=10; Start -> PC=0, Done=0, flags cleared.
REQ-046 Bench: Reset low during a BranchEn cycle -> PC=0, IDLE, Done=0, stack empty on the next edge.
